// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

   // Fetch sequencer states.
   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_t;

   // PC is word-addressed, so sequential fetch advances by one.
   localparam int unsigned PC_STEP = 1;

   // Default boot address.
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request
// at a time, buffers a response while ID stalls, and applies redirects with
// squash of the output slot, the hold buffer and any in-flight response.
module if_fetch
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pc_bj,
   input  logic [PC_W-1:0] target,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [PC_W-1:0] if_pc,
   output logic [31:0]     if_instr,
   input  logic            id_ready
);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_inc;
   logic            drop;        // in-flight response belongs to a squashed path
   logic [PC_W-1:0] hold_pc;
   logic [31:0]     hold_instr;
   logic            slot_free;

   // Wraps modulo 2^PC_W with no flag.
   assign pc_inc    = pc + PC_W'(PC_STEP);
   assign imem_addr = pc;
   assign slot_free = !if_valid || id_ready;

   // Next-state selection and request generation.
   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      case (state)
         S_BOOT: state_next = S_REQ;
         S_REQ: begin
            imem_req = 1'b1;
            // A redirect coincident with gnt still waits for the accepted response.
            if (imem_gnt) state_next = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (drop || pc_bj || slot_free) state_next = S_REQ;
               else                            state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (pc_bj || id_ready) state_next = S_REQ;
         end
         default: state_next = S_BOOT;
      endcase
   end

   // State, PC, squash flag, output slot and hold buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_BOOT;
         pc         <= RESET_PC;
         drop       <= 1'b0;
         if_valid   <= 1'b0;
         if_pc      <= '0;
         if_instr   <= '0;
         hold_pc    <= '0;
         hold_instr <= '0;
      end else begin
         state <= state_next;
         if (pc_bj) begin
            // Redirect wins over everything; the slot is squashed even if ID stalls.
            pc       <= target;
            if_valid <= 1'b0;
            if (state == S_REQ && imem_gnt) drop <= 1'b1;
            else if (state == S_WAIT)       drop <= !imem_rvalid;
         end else begin
            if (if_valid && id_ready) if_valid <= 1'b0;
            case (state)
               S_WAIT: begin
                  if (imem_rvalid) begin
                     if (drop) begin
                        drop <= 1'b0;
                     end else if (slot_free) begin
                        if_valid <= 1'b1;
                        if_pc    <= pc;
                        if_instr <= imem_rdata;
                        pc       <= pc_inc;
                     end else begin
                        hold_pc    <= pc;
                        hold_instr <= imem_rdata;
                        pc         <= pc_inc;
                     end
                  end
               end
               S_HOLD: begin
                  if (id_ready) begin
                     if_valid <= 1'b1;
                     if_pc    <= hold_pc;
                     if_instr <= hold_instr;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: boot, throughput, stall/hold, redirects,
// async reset, and PC wrap with a slow memory on a second instance.
module tb_if_fetch;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, pc_bj, id_ready;
   logic [31:0] target;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc, if_instr;

   logic        w_rst_n, w_pc_bj, w_id_ready;
   logic [31:0] w_target;
   logic        w_req, w_gnt, w_rvalid;
   logic [31:0] w_addr, w_rdata;
   logic        w_valid;
   logic [31:0] w_if_pc, w_if_instr;

   int n_chk  = 0;
   int n_fail = 0;

   // memory model state
   int          rv_dly;
   int          cnt;
   logic        pend;
   logic [31:0] gaddr;

   always #5 clk = ~clk;

   if_fetch u_dut (
      .clk(clk), .rst_n(rst_n), .pc_bj(pc_bj), .target(target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready)
   );

   if_fetch #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
      .clk(clk), .rst_n(w_rst_n), .pc_bj(w_pc_bj), .target(w_target),
      .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .if_valid(w_valid), .if_pc(w_if_pc), .if_instr(w_if_instr), .id_ready(w_id_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_slot(input string tag, input logic [31:0] pc_e, input int max);
      int n = 0;
      while (!if_valid && n < max) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(if_valid), 32'd1);
      chk({tag, "_pc"}, if_pc, pc_e);
      chk({tag, "_instr"}, if_instr, 32'h1000_0000 + pc_e);
   endtask

   task automatic wait_for(input string tag, input fetch_state_t st, input logic [31:0] addr,
                           input int max);
      int n = 0;
      while (!(u_dut.state == st && imem_addr == addr) && n < max) begin
         tick();
         n++;
      end
      chk(tag, (u_dut.state == st && imem_addr == addr) ? 32'd1 : 32'd0, 32'd1);
   endtask

   // one slow fetch on the wrap instance: gnt after 2 cycles, rvalid 3 after gnt
   task automatic w_fetch(input logic [31:0] a);
      chk("w_req", 32'(w_req), 32'd1);
      chk("w_addr", w_addr, a);
      repeat (2) begin
         tick();
         chk("w_req_held", 32'(w_req), 32'd1);
      end
      w_gnt = 1'b1;
      tick();
      w_gnt = 1'b0;
      chk("w_req_off", 32'(w_req), 32'd0);
      repeat (2) tick();
      w_rvalid = 1'b1;
      w_rdata  = 32'hC000_0000 ^ a;
      tick();
      w_rvalid = 1'b0;
      chk("w_valid", 32'(w_valid), 32'd1);
      chk("w_pc", w_if_pc, a);
      chk("w_instr", w_if_instr, 32'hC000_0000 ^ a);
      chk("w_next_addr", w_addr, a + 32'd1);
   endtask

   // memory for the main instance: immediate gnt, rvalid rv_dly cycles later
   initial begin
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      pend = 1'b0; cnt = 0; gaddr = '0;
      forever begin
         @(negedge clk);
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else if (pend) begin
            cnt++;
            if (cnt >= rv_dly) begin
               imem_rvalid = 1'b1;
               imem_rdata  = 32'h1000_0000 + gaddr;
               pend        = 1'b0;
            end
         end else if (imem_req) begin
            imem_gnt = 1'b1;
            gaddr    = imem_addr;
            pend     = 1'b1;
            cnt      = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; pc_bj = 1'b0; target = '0; id_ready = 1'b1; rv_dly = 1;
      w_rst_n = 1'b0; w_pc_bj = 1'b0; w_target = '0; w_id_ready = 1'b1;
      w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;

      // reset and boot
      tick();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      chk("boot_req", 32'(imem_req), 32'd0);
      tick();
      chk("req0", 32'(imem_req), 32'd1);
      chk("addr0", imem_addr, 32'd0);
      tick(); tick();
      chk("s0_valid", 32'(if_valid), 32'd1);
      chk("s0_pc", if_pc, 32'd0);
      chk("s0_instr", if_instr, 32'h1000_0000);
      tick();
      chk("s0_consumed", 32'(if_valid), 32'd0);
      tick();
      chk("s1_pc", if_pc, 32'd1);
      chk("s1_instr", if_instr, 32'h1000_0001);
      tick(); tick();
      chk("s2_valid", 32'(if_valid), 32'd1);
      chk("s2_pc", if_pc, 32'd2);

      // stall with a completed fetch parked in the hold buffer
      repeat (6) tick();
      chk("s5_pc", if_pc, 32'd5);
      id_ready = 1'b0;
      repeat (2) tick();
      chk("hold_state", 32'(u_dut.state), 32'(S_HOLD));
      chk("hold_pc5", if_pc, 32'd5);
      chk("hold_valid", 32'(if_valid), 32'd1);
      tick();
      chk("hold_state2", 32'(u_dut.state), 32'(S_HOLD));
      chk("hold_pc5b", if_pc, 32'd5);
      chk("hold_noreq", 32'(imem_req), 32'd0);
      id_ready = 1'b1;
      tick();
      chk("unhold_pc", if_pc, 32'd6);
      chk("unhold_instr", if_instr, 32'h1000_0006);
      chk("unhold_addr", imem_addr, 32'd7);
      chk("unhold_req", 32'(imem_req), 32'd1);

      // redirect while waiting for the response of pc=8
      rv_dly = 3;
      wait_for("reach_wait8", S_WAIT, 32'd8, 20);
      pc_bj = 1'b1; target = 32'h40;
      tick();
      pc_bj = 1'b0;
      chk("rw_state", 32'(u_dut.state), 32'(S_WAIT));
      chk("rw_addr", imem_addr, 32'h40);
      chk("rw_valid", 32'(if_valid), 32'd0);
      rv_dly = 1;
      wait_slot("rw", 32'h40, 20);
      chk("rw_next_addr", imem_addr, 32'h41);

      // redirect coincident with gnt for pc=3
      pc_bj = 1'b1; target = 32'd3;
      tick();
      pc_bj = 1'b0;
      wait_for("reach_req3", S_REQ, 32'd3, 20);
      chk("rg_req3", 32'(imem_req), 32'd1);
      pc_bj = 1'b1; target = 32'h80;
      tick();
      pc_bj = 1'b0;
      chk("rg_state", 32'(u_dut.state), 32'(S_WAIT));
      chk("rg_addr", imem_addr, 32'h80);
      chk("rg_valid", 32'(if_valid), 32'd0);
      tick();
      chk("rg_state2", 32'(u_dut.state), 32'(S_REQ));
      chk("rg_valid2", 32'(if_valid), 32'd0);
      chk("rg_req80", 32'(imem_req), 32'd1);
      chk("rg_addr2", imem_addr, 32'h80);
      wait_slot("rg", 32'h80, 20);

      // redirect while the slot is stalled and the hold buffer is full
      id_ready = 1'b0;
      wait_for("reach_hold", S_HOLD, 32'h82, 20);
      chk("rh_valid", 32'(if_valid), 32'd1);
      chk("rh_pc", if_pc, 32'h80);
      pc_bj = 1'b1; target = 32'h20;
      tick();
      pc_bj = 1'b0;
      id_ready = 1'b1;
      chk("rh_valid_off", 32'(if_valid), 32'd0);
      chk("rh_state", 32'(u_dut.state), 32'(S_REQ));
      chk("rh_addr", imem_addr, 32'h20);
      chk("rh_req", 32'(imem_req), 32'd1);
      wait_slot("rh", 32'h20, 20);

      // asynchronous reset takes effect without a clock edge
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(if_valid), 32'd0);
      chk("arst_pc", if_pc, 32'd0);
      chk("arst_instr", if_instr, 32'd0);
      chk("arst_req", 32'(imem_req), 32'd0);
      chk("arst_state", 32'(u_dut.state), 32'(S_BOOT));

      // wrap-around with slow memory on the second instance
      tick();
      w_rst_n = 1'b1;
      chk("w_boot_req", 32'(w_req), 32'd0);
      tick();
      w_fetch(32'hFFFF_FFFF);
      w_fetch(32'h0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
